// File: rtl/snn_pkg.sv
// Shared constants for the spiking-neural-network blocks: default weight width
// and the accumulate-mode encodings.
package snn_pkg;
  localparam int WEIGHT_W  = 32;
  localparam int ACC_EDGE  = 1;
  localparam int ACC_LEVEL = 0;
endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a clk-synchronous spike line. spike_d clears on reset,
// so a line already high at release is reported as an edge.
module spike_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic spike_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spike_d <= 1'b0;
    else      spike_d <= in;
  end

  assign rise = in & ~spike_d;
endmodule

// File: rtl/spike_weight_accumulator.sv
// Per-synapse accumulator: adds spike_weight to a running total on every
// accumulate event, with a sticky overflow flag and optional clamping.
module spike_weight_accumulator
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = WEIGHT_W,
  parameter int SATURATE   = 1,
  parameter int EDGE_MODE  = ACC_EDGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spike_in,
  input  logic [DATA_WIDTH-1:0] spike_weight,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sat
);
  logic                acc_en;
  logic [DATA_WIDTH:0] sum;

  generate
    if (EDGE_MODE == ACC_EDGE) begin : g_edge
      spike_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (spike_in),
        .rise (acc_en)
      );
    end else begin : g_level
      assign acc_en = spike_in;
    end
  endgenerate

  // One extra bit so the carry-out reports overflow.
  assign sum = {1'b0, dout} + {1'b0, spike_weight};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (acc_en) begin
      if (sum[DATA_WIDTH]) begin
        sat  <= 1'b1;
        dout <= (SATURATE != 0) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
      end else begin
        dout <= sum[DATA_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_spike_weight_accumulator.sv
// Directed bench: edge and level 32-bit accumulators share one spike/weight pair,
// saturating and wrapping 8-bit accumulators share another.
module tb_spike_weight_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sp32 = 1'b0;
  logic [31:0] w32 = '0;
  logic        sp8 = 1'b0;
  logic [7:0]  w8 = '0;
  logic [31:0] d_e, d_l;
  logic [7:0]  d_s, d_w;
  logic        s_e, s_l, s_s, s_w;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  spike_weight_accumulator #(.DATA_WIDTH(32), .SATURATE(1), .EDGE_MODE(1)) u_e (
    .clk(clk), .rst(rst), .spike_in(sp32), .spike_weight(w32), .dout(d_e), .sat(s_e));
  spike_weight_accumulator #(.DATA_WIDTH(32), .SATURATE(1), .EDGE_MODE(0)) u_l (
    .clk(clk), .rst(rst), .spike_in(sp32), .spike_weight(w32), .dout(d_l), .sat(s_l));
  spike_weight_accumulator #(.DATA_WIDTH(8), .SATURATE(1), .EDGE_MODE(1)) u_s (
    .clk(clk), .rst(rst), .spike_in(sp8), .spike_weight(w8), .dout(d_s), .sat(s_s));
  spike_weight_accumulator #(.DATA_WIDTH(8), .SATURATE(0), .EDGE_MODE(1)) u_w (
    .clk(clk), .rst(rst), .spike_in(sp8), .spike_weight(w8), .dout(d_w), .sat(s_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse32();
    @(negedge clk) sp32 = 1'b1;
    @(negedge clk) sp32 = 1'b0;
  endtask

  task automatic pulse8();
    @(negedge clk) sp8 = 1'b1;
    @(negedge clk) sp8 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    // 1: reset held with spikes toggling
    w32 = 32'd9; w8 = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sp32 = ~sp32; sp8 = ~sp8;
      chk("rst_dout_e", d_e, 32'd0);
      chk("rst_dout_l", d_l, 32'd0);
      chk("rst_sat_s", {31'd0, s_s}, 32'd0);
    end
    @(negedge clk) begin sp32 = 1'b0; sp8 = 1'b0; rst = 1'b1; end
    @(negedge clk);
    chk("release_dout", d_e, 32'd0);
    chk("release_sat", {31'd0, s_e}, 32'd0);

    // 2: three single-cycle spikes 4 cycles apart
    w32 = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) sp32 = 1'b1;
      chk("edge_before", d_e, 32'd5 * i);
      @(negedge clk) sp32 = 1'b0;
      chk("edge_after", d_e, 32'd5 * (i + 1));
      repeat (2) @(negedge clk);
    end
    chk("edge_hold", d_e, 32'd15);

    // 3: held spike, edge vs level
    do_reset();
    w32 = 32'd7;
    @(negedge clk) sp32 = 1'b1;
    repeat (10) @(negedge clk);
    sp32 = 1'b0;
    chk("held_edge", d_e, 32'd7);
    chk("held_level", d_l, 32'd70);
    // back-to-back 1,0,1 counts twice
    pulse32();
    pulse32();
    chk("b2b_edge", d_e, 32'd21);

    // 4: weight change
    do_reset();
    w32 = 32'd3;    pulse32(); chk("wchg_3", d_e, 32'h3);
    w32 = 32'h10;   pulse32(); chk("wchg_13", d_e, 32'h13);
    w32 = 32'd0;    pulse32(); chk("wchg_zero", d_e, 32'h13);
    chk("wchg_sat", {31'd0, s_e}, 32'd0);

    // 5: 8-bit overflow, clamp vs wrap
    do_reset();
    w32 = 32'h40; pulse32(); chk("pre_async", d_e, 32'h40);
    w8 = 8'hF0;
    pulse8();
    chk("ovf1_sat_d", {24'd0, d_s}, 32'hF0);
    chk("ovf1_sat_f", {31'd0, s_s}, 32'd0);
    pulse8();
    chk("ovf2_sat_d", {24'd0, d_s}, 32'hFF);
    chk("ovf2_sat_f", {31'd0, s_s}, 32'd1);
    chk("ovf2_wrap_d", {24'd0, d_w}, 32'hE0);
    chk("ovf2_wrap_f", {31'd0, s_w}, 32'd1);
    pulse8();
    chk("ovf3_sat_d", {24'd0, d_s}, 32'hFF);
    chk("ovf3_sat_f", {31'd0, s_s}, 32'd1);

    // 6: async reset between clock edges
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_dout_e", d_e, 32'd0);
    chk("async_dout_s", {24'd0, d_s}, 32'd0);
    chk("async_sat_s", {31'd0, s_s}, 32'd0);
    chk("async_sat_w", {31'd0, s_w}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_async", d_e, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
